// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - control/status bundle between the ALU sequencer and the surrounding core
interface alu_sequencer_if;
  logic       Start;
  logic       Mem_Ready;
  logic [1:0] Opcode;
  logic       Zero;
  logic       Mem_Read;
  logic       IR_Write;
  logic       RegWrite;
  logic       PC_Write;
  logic       ALU_OP;
  logic       Branch;
  logic       Imm_Sel;
  logic       Busy;
  logic       Halted;
  logic [7:0] Retired;
  logic [2:0] State;

  modport master (
    output Start, Mem_Ready, Opcode, Zero,
    input  Mem_Read, IR_Write, RegWrite, PC_Write, ALU_OP, Branch, Imm_Sel,
    input  Busy, Halted, Retired, State
  );

  modport slave (
    input  Start, Mem_Ready, Opcode, Zero,
    output Mem_Read, IR_Write, RegWrite, PC_Write, ALU_OP, Branch, Imm_Sel,
    output Busy, Halted, Retired, State
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control FSM sequencing the shared 8-bit ALU
module alu_sequencer (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] PCINC  = 3'd5;
  localparam logic [2:0] BRANCH = 3'd6;
  localparam logic [2:0] HALT   = 3'd7;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       op_shift;
  logic [7:0] retired;
  logic       pc_write;

  // Opcode is captured in DECODE so EXEC/WB controls stay Moore-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_shift <= 1'b0;
      retired  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) op_shift <= bus.Opcode[0];
      if (pc_write) retired <= retired + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = FETCH;
      FETCH:   if (bus.Mem_Ready) state_nxt = DECODE;
      DECODE: begin
        case (bus.Opcode)
          2'b10:   state_nxt = BRANCH;
          2'b11:   state_nxt = HALT;
          default: state_nxt = EXEC;
        endcase
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = PCINC;
      PCINC:   state_nxt = FETCH;
      BRANCH:  state_nxt = bus.Zero ? FETCH : PCINC;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Mem_Read = 1'b0;
    bus.IR_Write = 1'b0;
    bus.RegWrite = 1'b0;
    pc_write     = 1'b0;
    bus.ALU_OP   = 1'b0;
    bus.Branch   = 1'b0;
    bus.Imm_Sel  = 1'b0;
    case (state)
      FETCH: begin
        bus.Mem_Read = 1'b1;
        bus.IR_Write = bus.Mem_Ready;
      end
      EXEC:  bus.ALU_OP = op_shift;
      WB: begin
        bus.ALU_OP   = op_shift;
        bus.RegWrite = 1'b1;
      end
      // PC + 1 through the shared ALU: PC on A, constant 1 on B.
      PCINC: begin
        bus.Branch  = 1'b1;
        bus.Imm_Sel = 1'b1;
        pc_write    = 1'b1;
      end
      BRANCH: begin
        bus.Branch = 1'b1;
        pc_write   = bus.Zero;
      end
      default: ;
    endcase
  end

  assign bus.PC_Write = pc_write;
  assign bus.Busy     = (state != IDLE) && (state != HALT);
  assign bus.Halted   = (state == HALT);
  assign bus.Retired  = retired;
  assign bus.State    = state;

endmodule
